// File: rtl/shifter_pkg.sv
// Shared encodings, widths and request payload for the multi-cycle right shifter.
package shifter_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned SHAMT_W = 6;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned STAGE_W = 3;

    localparam logic [OP_W-1:0] OP_SRL = 2'b00;
    localparam logic [OP_W-1:0] OP_SRA = 2'b01;
    localparam logic [OP_W-1:0] OP_ROR = 2'b10;

    // Index of the first (largest, 32-bit) stage applied after accept.
    localparam logic [STAGE_W-1:0] FIRST_STAGE = STAGE_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Request captured at accept.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic [OP_W-1:0]    op;
    } shr_req_t;

endpackage

// File: rtl/shr_stage_64.sv
// One logarithmic right-shift stage: shifts by 2^k when enabled, else passes through.
module shr_stage_64
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0]  d_i,
    input  logic [STAGE_W-1:0] k_i,
    input  logic               en_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               sign_i,
    output logic [DATA_W-1:0]  d_o
);

    logic [DATA_W-1:0]   fill;
    logic [2*DATA_W-1:0] ext;
    logic [2*DATA_W-1:0] shifted;
    logic [7:0]          amt;

    // Fill word supplies the bits entering from the top: zeros, sign copies or the operand itself.
    always_comb begin
        fill = '0;
        case (op_i)
            OP_SRA:  fill = {DATA_W{sign_i}};
            OP_ROR:  fill = d_i;
            default: fill = '0;
        endcase
        amt     = 8'(1) << k_i;
        ext     = {fill, d_i};
        shifted = ext >> amt;
        d_o     = en_i ? shifted[DATA_W-1:0] : d_i;
    end

endmodule

// File: rtl/shifter_rseq_64.sv
// Multi-cycle 64-bit right shifter (SRL/SRA/ROR), one log stage per clock, valid/ready on both sides.
module shifter_rseq_64
    import shifter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [OP_W-1:0]    in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);

    state_e             state_q;
    shr_req_t           req_q;
    logic               sign_q;
    logic [STAGE_W-1:0] k_q;
    logic [DATA_W-1:0]  out_data_q;

    logic [DATA_W-1:0]  stage_d;
    logic               stage_en;

    // Shift bit for the current stage; mask form avoids indexing past the 6-bit amount.
    assign stage_en = |(req_q.shamt & (SHAMT_W'(1) << k_q));

    // Single shared stage, re-used each BUSY cycle with a decrementing stage index.
    shr_stage_64 u_stage (
        .d_i    (req_q.data),
        .k_i    (k_q),
        .en_i   (stage_en),
        .op_i   (req_q.op),
        .sign_i (sign_q),
        .d_o    (stage_d)
    );

    // Control FSM and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            sign_q     <= 1'b0;
            k_q        <= '0;
            out_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        req_q.data  <= in_data;
                        req_q.shamt <= in_shamt;
                        req_q.op    <= in_op;
                        sign_q      <= in_data[DATA_W-1];
                        k_q         <= FIRST_STAGE;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    req_q.data <= stage_d;
                    out_data_q <= stage_d;
                    if (k_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q - STAGE_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decoded from state only; forced low while reset is asserted.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = rst_n && (state_q == DONE);
    assign out_data  = out_data_q;

endmodule

// File: doc/shifter_rseq_64.md
# shifter_rseq_64

Multi-cycle 64-bit right shifter: the right-shifting counterpart to the datapath's combinational 6-stage left barrel shifter, used by the execute stage for SRL/SRA/ROR. It applies one logarithmic stage per clock (32, 16, 8, 4, 2, 1) under a small FSM, with valid/ready handshakes on both sides. Fixed latency trades area for throughput.

## Interface
- No parameters; width fixed at 64 data bits, 6-bit shift amount.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_data  in  64  operand
- in_shamt  in  6  shift amount, 0..63
- in_op  in  2  00 SRL, 01 SRA, 10 ROR, 11 reserved (executes as SRL)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  64  shifted result

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge, capture in_data, in_shamt, in_op; set stage counter to 5; go to BUSY.
- BUSY: each edge applies stage k (amount 2^k) if shamt[k]=1, else passes data unchanged; k decrements 5→0. After stage 0's edge, go to DONE.
- Stage semantics on 64-bit value d, amount s:
  - SRL: zero-fill from bit 63.
  - SRA: fill with captured original bit 63. Sign is latched at accept, not re-read per stage; value is identical either way.
  - ROR: bits shifted out of bit 0 re-enter at bit 63.
- DONE: out_valid=1, out_data = result, held stable until out_ready. On out_valid&out_ready at an edge, go to IDLE.
- in_ready=0 in BUSY and DONE. in_valid is ignored there; the upstream must hold its request.
- shamt=0 still takes the full BUSY sequence; output equals input.
- Reset (rst_n=0 at an edge) from any state, including mid-BUSY or DONE with pending output: state→IDLE, out_valid=0, out_data=0, internal data/shamt/op/counter cleared. The in-flight operation is discarded.
- While rst_n=0: in_ready=0, out_valid=0.

## Timing
- Accept at edge N. Stages 5..0 at edges N+1..N+6. out_valid=1 from after edge N+6.
- Minimum latency: 6 cycles from accept to out_valid.
- With out_ready=1 in the first DONE cycle, output handshake at edge N+7, IDLE after it. Next accept is possible at edge N+8. Peak throughput is 1 op per 8 cycles.
- out_data changes only on BUSY stage edges and reset. It is stable throughout DONE.
- in_ready and out_valid are decoded directly from state registers (no combinational path from in_valid/out_ready).

## Structure
- Shared package shifter_pkg holds:
  - op encodings: OP_SRL=2'b00, OP_SRA=2'b01, OP_ROR=2'b10
  - the FSM state enum: IDLE/BUSY/DONE
  - constants DATA_W=64, SHAMT_W=6
- Sub-module shr_stage_64 is combinational:
  - inputs: d[63:0], k[2:0], en, op, sign
  - output: d shifted right by 2^k per op when en, else d
  - instantiated once and reused across cycles by the top-level FSM/counter.

## Test plan
- SRL 0x8000_0000_0000_0000 by 63 → out_data 0x0000_0000_0000_0001; out_valid rises exactly 6 cycles after accept.
- SRA 0x8000_0000_0000_0000 by 4 → 0xF800_0000_0000_0000. SRA 0x7FFF_FFFF_FFFF_FFFF by 63 → 0x0.
- ROR 0x0000_0000_0000_0001 by 1 → 0x8000_0000_0000_0000. ROR 0x0123_4567_89AB_CDEF by 32 → 0x89AB_CDEF_0123_4567. op=11 with 0xF0 by 4 → 0x0F.
- Shift 0, any op, 0xDEAD_BEEF_CAFE_F00D → unchanged. Backpressure: out_ready low 5 cycles in DONE → out_data stable, in_ready=0, new in_valid not accepted; accepted 1 cycle after out handshake.
- rst_n low for one edge during BUSY (3rd stage) → next cycle out_valid=0, out_data=0, state IDLE. A fresh request then completes correctly with full 6-cycle latency.
